// File: rtl/aes256_key_expand.sv
// aes256_key_expand: iterative AES-256 key schedule, one 128-bit round key per clock
module aes256_key_expand #(
    parameter int NR = 14
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [255:0] key_in,
    output logic         busy,
    output logic         keys_valid,
    output logic         rk_wr_valid,
    output logic [3:0]   rk_wr_idx,
    output logic [127:0] rk_wr_data,
    input  logic [3:0]   rk_idx,
    output logic [127:0] rk_out
);
    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    state_t       state, nextState;
    logic [3:0]   cnt;
    logic [127:0] rk [0:NR];
    logic [127:0] prevKey, lastKey, newKey;
    logic [31:0]  subIn, subOut, tWord, o0, o1, o2, o3;
    logic [7:0]   rcon;
    logic         startOk;

    assign startOk    = start && state != EXPAND;
    assign busy       = state == EXPAND;
    assign keys_valid = state == DONE;
    assign rk_out     = rk_idx <= 4'(NR) ? rk[rk_idx] : '0;

    // the four S-box lookups shared by the even (RotWord) and odd word paths
    always_comb begin
        prevKey = rk[cnt - 4'd2];
        lastKey = rk[cnt - 4'd1];
        rcon    = 8'h01 << (cnt[3:1] - 3'd1);
        subIn   = cnt[0] ? lastKey[31:0] : {lastKey[23:0], lastKey[31:24]};
        subOut  = {SBOX[subIn[31:24]], SBOX[subIn[23:16]], SBOX[subIn[15:8]], SBOX[subIn[7:0]]};
        tWord   = cnt[0] ? subOut : subOut ^ {rcon, 24'h0};
        o0      = prevKey[127:96] ^ tWord;
        o1      = prevKey[95:64] ^ o0;
        o2      = prevKey[63:32] ^ o1;
        o3      = prevKey[31:0] ^ o2;
        newKey  = {o0, o1, o2, o3};
    end

    // state register
    always_ff @(posedge clk) begin
        state <= !rst_n ? IDLE : nextState;
    end

    // next state: start is honoured only outside EXPAND, which ends once rk14 is written
    always_comb begin
        nextState = state;
        if (state == EXPAND) nextState = cnt == 4'(NR) ? DONE : EXPAND;
        else if (start) nextState = EXPAND;
    end

    // register file writes and the streamed copy of each key as it lands
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt         <= '0;
            rk_wr_valid <= 1'b0;
            rk_wr_idx   <= '0;
            rk_wr_data  <= '0;
            for (int i = 0; i <= NR; i++) rk[i] <= '0;
        end else begin
            rk_wr_valid <= 1'b0;
            if (startOk) begin
                rk[0]       <= key_in[255:128];
                rk[1]       <= key_in[127:0];
                cnt         <= 4'd2;
                rk_wr_valid <= 1'b1;
                rk_wr_idx   <= 4'd1;
                rk_wr_data  <= key_in[127:0];
            end else if (state == EXPAND) begin
                rk[cnt]     <= newKey;
                cnt         <= cnt + 4'd1;
                rk_wr_valid <= 1'b1;
                rk_wr_idx   <= cnt;
                rk_wr_data  <= newKey;
            end
        end
    end
endmodule

// File: tb/tb_aes256_key_expand.sv
// tb_aes256_key_expand: directed-vector bench for the AES-256 key schedule
module tb_aes256_key_expand;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [255:0] key_in;
    logic         busy, keys_valid, rk_wr_valid;
    logic [3:0]   rk_wr_idx, rk_idx;
    logic [127:0] rk_wr_data, rk_out, rdVal;
    int           testsRun = 0;
    int           testsFailed = 0;

    localparam logic [255:0] KEY_A3  = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [255:0] KEY_ALT = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] A3_RK2  = 128'h9ba354118e6925afa51a8b5f2067fcde;
    localparam logic [127:0] A3_RK3  = 128'ha8b09c1a93d194cdbe49846eb75d5b9a;
    localparam logic [127:0] A3_RK14 = 128'hfe4890d1e6188d0b046df344706c631e;
    localparam logic [127:0] Z_RK2   = 128'h62636363626363636263636362636363;
    localparam logic [127:0] Z_RK3   = 128'haafbfbfbaafbfbfbaafbfbfbaafbfbfb;

    aes256_key_expand dut (
        .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in),
        .busy(busy), .keys_valid(keys_valid), .rk_wr_valid(rk_wr_valid),
        .rk_wr_idx(rk_wr_idx), .rk_wr_data(rk_wr_data),
        .rk_idx(rk_idx), .rk_out(rk_out)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [127:0] got, input logic [127:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic readRk(input int i, output logic [127:0] v);
        rk_idx = 4'(i);
        #1;
        v = rk_out;
    endtask

    task automatic checkIdle(input string tag);
        checkVal({tag, " busy"}, 128'(busy), 128'd0);
        checkVal({tag, " keys_valid"}, 128'(keys_valid), 128'd0);
        checkVal({tag, " wr_valid"}, 128'(rk_wr_valid), 128'd0);
        checkVal({tag, " wr_idx"}, 128'(rk_wr_idx), 128'd0);
        checkVal({tag, " wr_data"}, rk_wr_data, 128'd0);
        for (int i = 0; i < 16; i++) begin
            readRk(i, rdVal);
            checkVal($sformatf("%s rk_out[%0d]", tag, i), rdVal, 128'd0);
        end
    endtask

    // start on E0, optionally re-pulse start (with another key) so it is sampled at edge E0+ignoreAt
    task automatic runExpand(input string tag, input logic [255:0] key, input int ignoreAt);
        start = 1'b1;
        key_in = key;
        tick();
        start = 1'b0;
        key_in = ~key;
        checkVal({tag, " E0 busy"}, 128'(busy), 128'd1);
        checkVal({tag, " E0 keys_valid"}, 128'(keys_valid), 128'd0);
        checkVal({tag, " E0 wr_valid"}, 128'(rk_wr_valid), 128'd1);
        checkVal({tag, " E0 wr_idx"}, 128'(rk_wr_idx), 128'd1);
        checkVal({tag, " E0 wr_data"}, rk_wr_data, key[127:0]);
        for (int k = 1; k <= 13; k++) begin
            if (k == ignoreAt) begin
                start = 1'b1;
                key_in = KEY_ALT;
            end
            tick();
            start = 1'b0;
            checkVal($sformatf("%s E%0d wr_valid", tag, k), 128'(rk_wr_valid), 128'd1);
            checkVal($sformatf("%s E%0d wr_idx", tag, k), 128'(rk_wr_idx), 128'(k + 1));
            checkVal($sformatf("%s E%0d keys_valid", tag, k), 128'(keys_valid), 128'(k == 13));
            readRk(k + 1, rdVal);
            checkVal($sformatf("%s E%0d wr_data", tag, k), rk_wr_data, rdVal);
        end
        tick();
        checkVal({tag, " post wr_valid"}, 128'(rk_wr_valid), 128'd0);
        checkVal({tag, " post busy"}, 128'(busy), 128'd0);
        checkVal({tag, " post keys_valid"}, 128'(keys_valid), 128'd1);
    endtask

    task automatic checkA3(input string tag);
        readRk(0, rdVal);
        checkVal({tag, " rk0"}, rdVal, KEY_A3[255:128]);
        readRk(1, rdVal);
        checkVal({tag, " rk1"}, rdVal, KEY_A3[127:0]);
        readRk(2, rdVal);
        checkVal({tag, " rk2"}, rdVal, A3_RK2);
        readRk(3, rdVal);
        checkVal({tag, " rk3"}, rdVal, A3_RK3);
        readRk(14, rdVal);
        checkVal({tag, " rk14"}, rdVal, A3_RK14);
        readRk(15, rdVal);
        checkVal({tag, " rk15"}, rdVal, 128'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        key_in = '0;
        rk_idx = '0;
        tick();
        tick();
        rst_n = 1'b1;
        checkIdle("reset");

        runExpand("a3", KEY_A3, 5);
        checkA3("a3");

        start = 1'b1;
        key_in = KEY_A3;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 5; k++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checkIdle("midreset");

        runExpand("rerun", KEY_A3, 0);
        checkA3("rerun");

        runExpand("zero", 256'd0, 0);
        readRk(0, rdVal);
        checkVal("zero rk0", rdVal, 128'd0);
        readRk(2, rdVal);
        checkVal("zero rk2", rdVal, Z_RK2);
        readRk(3, rdVal);
        checkVal("zero rk3", rdVal, Z_RK3);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
